// File: rtl/bitonic_sort_scheduler.sv
// bitonic_sort_scheduler: round-robin front end that shares one pipelined
// bitonic sorter between NUM_REQ requesters. The sorter has no valid/stall,
// so a {valid,id} shadow pipe rides alongside it. Results land in a credit-
// protected FIFO and leave in issue order.
module bitonic_sort_scheduler #(
   parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
   parameter int NUM_WAY                  = 16,
   parameter int NUM_REQ                  = 4,
   parameter int SORT_LATENCY             = 3,
   parameter int FIFO_DEPTH               = 4,
   parameter int ID_WIDTH                 = 2
) (
   input  logic                                                clk_in,
   input  logic                                                reset_n_in,
   input  logic [NUM_REQ-1:0]                                  req_valid_in,
   input  logic [NUM_REQ*SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] req_data_flatted_in,
   output logic [NUM_REQ-1:0]                                  req_ready_out,
   output logic                                                sorter_reset_out,
   output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0]         sorter_pre_sort_flatted_out,
   input  logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0]         sorter_post_sort_flatted_in,
   output logic                                                resp_valid_out,
   output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0]         resp_data_flatted_out,
   output logic [ID_WIDTH-1:0]                                 resp_id_out,
   input  logic                                                resp_ready_in,
   output logic                                                busy_out
);

   localparam int VW  = SINGLE_WAY_WIDTH_IN_BITS * NUM_WAY;
   localparam int RRW = $clog2(NUM_REQ);
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int OCW = $clog2(FIFO_DEPTH + 1);

   typedef struct packed {
      logic [ID_WIDTH-1:0] id;
      logic [VW-1:0]       data;
   } resp_t;

   logic [NUM_REQ-1:0][VW-1:0]       req_data;
   logic [RRW-1:0]                   rr_ptr;
   logic [RRW-1:0]                   grant_idx;
   logic [RRW-1:0]                   scan_idx;
   logic                             grant_any;
   logic                             can_issue;
   logic                             issue;
   logic                             pop;
   logic [OCW-1:0]                   outstanding;
   logic [SORT_LATENCY:1]            vld_pipe;
   logic [SORT_LATENCY:1][ID_WIDTH-1:0] id_pipe;
   resp_t                            fifo_mem [FIFO_DEPTH];
   resp_t                            head;
   logic [PW-1:0]                    wr_ptr;
   logic [PW-1:0]                    rd_ptr;
   logic [OCW-1:0]                   fifo_cnt;
   logic                             fifo_wr;
   logic                             fifo_full;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign req_data         = req_data_flatted_in;
   assign sorter_reset_out = ~reset_n_in;

   // FIFO status and head
   assign resp_valid_out        = (fifo_cnt != '0);
   assign fifo_full             = (fifo_cnt == OCW'(FIFO_DEPTH));
   assign fifo_wr               = vld_pipe[SORT_LATENCY];
   assign pop                   = resp_valid_out & resp_ready_in;
   assign head                  = fifo_mem[rd_ptr];
   assign resp_data_flatted_out = resp_valid_out ? head.data : '0;
   assign resp_id_out           = resp_valid_out ? head.id : '0;
   assign busy_out              = (outstanding != '0);

   // a same-cycle pop hands its credit straight to a new issue
   assign can_issue = (int'(outstanding) - int'(pop)) < FIFO_DEPTH;
   assign issue     = reset_n_in & grant_any & can_issue;

   // round-robin scan: walk from farthest to nearest so the nearest valid wins
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         scan_idx = RRW'((int'(rr_ptr) + i) % NUM_REQ);
         if (req_valid_in[scan_idx]) begin
            grant_any = 1'b1;
            grant_idx = scan_idx;
         end
      end
   end

   // grant and sorter drive; sorter input is forced to zero when idle
   always_comb begin
      req_ready_out               = '0;
      sorter_pre_sort_flatted_out = '0;
      if (issue) begin
         req_ready_out               = NUM_REQ'(1) << grant_idx;
         sorter_pre_sort_flatted_out = req_data[grant_idx];
      end
   end

   // priority pointer moves to the winner only on an actual transfer
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in)  rr_ptr <= RRW'(NUM_REQ - 1);
      else if (issue)   rr_ptr <= grant_idx;
   end

   // shadow pipe marks which sorter stages hold live data and who owns them
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         vld_pipe <= '0;
         id_pipe  <= '0;
      end else begin
         vld_pipe[1] <= issue;
         id_pipe[1]  <= ID_WIDTH'(grant_idx);
         for (int s = 2; s <= SORT_LATENCY; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            id_pipe[s]  <= id_pipe[s-1];
         end
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (fifo_wr) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)     rd_ptr <= ptr_inc(rd_ptr);
         fifo_cnt <= fifo_cnt + OCW'(fifo_wr) - OCW'(pop);
      end
   end

   // FIFO storage; contents are masked at the output so no reset is needed
   always_ff @(posedge clk_in) begin
      if (fifo_wr) fifo_mem[wr_ptr] <= {id_pipe[SORT_LATENCY], sorter_post_sort_flatted_in};
   end

   // credits held = in flight + queued
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) outstanding <= '0;
      else             outstanding <= outstanding + OCW'(issue) - OCW'(pop);
   end

   // credits must make a write into a full FIFO impossible
   assert property (@(posedge clk_in) disable iff (!reset_n_in)
                    !(fifo_wr && fifo_full && !pop));
   assert property (@(posedge clk_in) disable iff (!reset_n_in)
                    int'(outstanding) <= FIFO_DEPTH);

endmodule

// File: tb/tb_bitonic_sort_scheduler.sv
// Bench for bitonic_sort_scheduler: behavioural sorter, queue-based reference
// model checked every cycle, plus directed literal checks.
module tb_bitonic_sort_scheduler;
   localparam int SW = 4, NW = 16, NR = 4, SL = 3, FD = 4, IW = 2;
   localparam int VW = SW * NW;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     req_valid;
   logic [NR*VW-1:0]  req_data;
   logic [NR-1:0]     req_ready;
   logic              sorter_reset;
   logic [VW-1:0]     pre_sort;
   logic [VW-1:0]     post_sort;
   logic              resp_valid;
   logic [VW-1:0]     resp_data;
   logic [IW-1:0]     resp_id;
   logic              resp_ready;
   logic              busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bitonic_sort_scheduler #(
      .SINGLE_WAY_WIDTH_IN_BITS(SW), .NUM_WAY(NW), .NUM_REQ(NR),
      .SORT_LATENCY(SL), .FIFO_DEPTH(FD), .ID_WIDTH(IW)
   ) dut (
      .clk_in(clk), .reset_n_in(rst_n),
      .req_valid_in(req_valid), .req_data_flatted_in(req_data),
      .req_ready_out(req_ready), .sorter_reset_out(sorter_reset),
      .sorter_pre_sort_flatted_out(pre_sort), .sorter_post_sort_flatted_in(post_sort),
      .resp_valid_out(resp_valid), .resp_data_flatted_out(resp_data),
      .resp_id_out(resp_id), .resp_ready_in(resp_ready), .busy_out(busy)
   );

   // behavioural sorter: bubble sort, SL register stages
   function automatic logic [VW-1:0] bubble(input logic [VW-1:0] v);
      logic [SW-1:0] a [NW];
      logic [SW-1:0] t;
      logic [VW-1:0] r;
      for (int i = 0; i < NW; i++) a[i] = v[i*SW +: SW];
      for (int i = 0; i < NW; i++)
         for (int j = 0; j < NW-1-i; j++)
            if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
      r = '0;
      for (int i = 0; i < NW; i++) r[i*SW +: SW] = a[i];
      return r;
   endfunction

   // reference sort by counting keys
   function automatic logic [VW-1:0] ref_sort(input logic [VW-1:0] v);
      int hist [16];
      int k;
      logic [VW-1:0] r;
      for (int i = 0; i < 16; i++) hist[i] = 0;
      for (int i = 0; i < NW; i++) hist[v[i*SW +: SW]]++;
      r = '0;
      k = 0;
      for (int val = 0; val < 16; val++)
         for (int c = 0; c < hist[val]; c++) begin
            r[k*SW +: SW] = SW'(val);
            k++;
         end
      return r;
   endfunction

   logic [VW-1:0] spipe [SL];
   always @(posedge clk or posedge sorter_reset) begin
      if (sorter_reset) begin
         for (int s = 0; s < SL; s++) spipe[s] <= '0;
      end else begin
         spipe[0] <= bubble(pre_sort);
         for (int s = 1; s < SL; s++) spipe[s] <= spipe[s-1];
      end
   end
   assign post_sort = spipe[SL-1];

   task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // reference model: queue of outstanding responses in issue order
   typedef struct {
      logic [VW-1:0] d;
      int            id;
      int            avail;
   } ent_t;
   ent_t          q [$];
   int            rr_m = NR - 1;
   int            cyc = 0;
   int            gidx;
   bit            exp_valid, pop_m, can_m, sorted_ok;
   logic [NR-1:0] exp_ready;
   logic [VW-1:0] exp_pre;

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         rr_m = NR - 1;
         chk("rst_ready", VW'(req_ready), '0);
         chk("rst_valid", VW'(resp_valid), '0);
         chk("rst_busy", VW'(busy), '0);
         chk("rst_sorter_reset", VW'(sorter_reset), 1);
         chk("rst_presort", pre_sort, '0);
         chk("rst_data", resp_data, '0);
         chk("rst_id", VW'(resp_id), '0);
      end else begin
         exp_valid = (q.size() > 0) && (q[0].avail <= cyc);
         pop_m     = exp_valid && resp_ready;
         can_m     = (q.size() - int'(pop_m)) < FD;
         gidx      = -1;
         if (can_m)
            for (int k = 1; k <= NR; k++)
               if (gidx < 0 && req_valid[(rr_m + k) % NR]) gidx = (rr_m + k) % NR;
         exp_ready = '0;
         exp_pre   = '0;
         if (gidx >= 0) begin
            exp_ready[gidx] = 1'b1;
            exp_pre         = req_data[gidx*VW +: VW];
         end
         chk("ready", VW'(req_ready), VW'(exp_ready));
         chk("presort", pre_sort, exp_pre);
         chk("resp_valid", VW'(resp_valid), VW'(exp_valid));
         chk("busy", VW'(busy), VW'(q.size() != 0));
         if (exp_valid) begin
            chk("resp_data", resp_data, q[0].d);
            chk("resp_id", VW'(resp_id), VW'(q[0].id));
            sorted_ok = 1'b1;
            for (int i = 0; i < NW-1; i++)
               if (resp_data[i*SW +: SW] > resp_data[(i+1)*SW +: SW]) sorted_ok = 1'b0;
            chk("ascending", VW'(sorted_ok), 1);
         end
         if (pop_m) void'(q.pop_front());
         if (gidx >= 0) begin
            q.push_back('{d: ref_sort(req_data[gidx*VW +: VW]), id: gidx, avail: cyc + SL + 1});
            rr_m = gidx;
         end
      end
      cyc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic rand_data();
      for (int r = 0; r < NR; r++) req_data[r*VW +: VW] = {$urandom(), $urandom()};
   endtask

   int grants;

   initial begin
      rst_n      = 1'b0;
      req_valid  = '0;
      req_data   = '0;
      resp_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;

      // 1: single request, fixed 4-cycle latency
      resp_ready = 1'b1;
      req_data[0 +: VW] = 64'h0123_4567_89AB_CDEF;
      req_valid = 4'b0001;
      #1 chk("t1_grant", VW'(req_ready), 1);
      step(); req_valid = '0;
      step();
      step();
      #1 chk("t1_not_yet", VW'(resp_valid), 0);
      step();
      #1 chk("t1_valid", VW'(resp_valid), 1);
      chk("t1_data", resp_data, 64'hFEDC_BA98_7654_3210);
      chk("t1_id", VW'(resp_id), 0);
      step();
      #1 chk("t1_drained", VW'(resp_valid), 0);

      // 2: all requesters, full rate rotation
      do_reset();
      rand_data();
      resp_ready = 1'b1;
      req_valid  = '1;
      for (int k = 0; k < 8; k++) begin
         #1 chk("t2_grant", VW'(req_ready), VW'(1) << (k % NR));
         if (k >= SL + 1) begin
            chk("t2_valid", VW'(resp_valid), 1);
            chk("t2_id", VW'(resp_id), VW'(k - SL - 1));
         end
         step();
      end
      repeat (8) step();
      req_valid = '0;
      repeat (8) step();

      // 3: consumer stalled, credits cap the grants
      do_reset();
      rand_data();
      resp_ready = 1'b0;
      req_valid  = 4'b0001;
      grants = 0;
      for (int k = 0; k < 10; k++) begin
         #1 grants += int'(req_ready[0]);
         step();
      end
      chk("t3_grants", VW'(grants), FD);
      #1 chk("t3_blocked", VW'(req_ready), 0);

      // 4: full FIFO, pop and issue in the same cycle
      resp_ready = 1'b1;
      #1 chk("t4_grant_on_pop", VW'(req_ready), 1);
      chk("t4_busy", VW'(busy), 1);
      step();
      resp_ready = 1'b0;
      #1 chk("t4_still_full", VW'(req_ready), 0);
      step();
      resp_ready = 1'b1;
      repeat (12) step();
      req_valid = '0;
      repeat (8) step();

      // 5: reset with 2 in flight and 2 queued
      do_reset();
      rand_data();
      resp_ready = 1'b0;
      req_valid  = '1;
      repeat (4) step();
      req_valid = '0;
      step();
      #1 chk("t5_pre_valid", VW'(resp_valid), 1);
      chk("t5_pre_busy", VW'(busy), 1);
      rst_n = 1'b0;
      #1 chk("t5_rst_valid", VW'(resp_valid), 0);
      chk("t5_rst_busy", VW'(busy), 0);
      chk("t5_rst_sorter", VW'(sorter_reset), 1);
      step();
      chk("t5_edge_valid", VW'(resp_valid), 0);
      rst_n = 1'b1;
      resp_ready = 1'b1;
      req_data[0 +: VW] = 64'h0123_4567_89AB_CDEF;
      req_valid = 4'b0001;
      #1 chk("t5_grant", VW'(req_ready), 1);
      step(); req_valid = '0;
      step();
      step();
      #1 chk("t5_not_yet", VW'(resp_valid), 0);
      step();
      #1 chk("t5_valid", VW'(resp_valid), 1);
      chk("t5_data", resp_data, 64'hFEDC_BA98_7654_3210);
      step();

      // 6: random traffic
      do_reset();
      for (int k = 0; k < 10000; k++) begin
         rand_data();
         req_valid  = NR'($urandom_range(0, (1 << NR) - 1));
         resp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      req_valid  = '0;
      resp_ready = 1'b1;
      repeat (20) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
